pp_cmd_issuer: RTL and testbench
================================

// Module: pp_cmd_issuer
// PURPOSE
// - Command initiator for the pp datapath core: accepts host requests (opcode + two fixed-point operands),
//   drives the core's cmd/in1/in2 inputs, waits for the core's valid, and returns result/status to the host.
// - Sits between the PYNQ host-side stream adapter and the pp core. One command in flight at a time.
// PARAMETERS
// - NUM_SIZE      32    operand/result width, signed fixed-point
// - MAX_OP        4'd1  highest opcode the core implements; larger opcodes are rejected locally
// - TIMEOUT       255   WAIT cycles before a command is abandoned (>=1)
// PORTS
// - clk           in   1         single clock
// - reset_n       in   1         asynchronous active-low reset
// - req_valid     in   1         host request valid
// - req_ready     out  1         issuer can accept a request
// - req_op        in   4         opcode (pp_pkg::op_t)
// - req_a         in   NUM_SIZE  operand 1
// - req_b         in   NUM_SIZE  operand 2
// - rsp_valid     out  1         response valid
// - rsp_ready     in   1         host accepts response
// - rsp_data      out  NUM_SIZE  core result (0 on error/NOOP)
// - rsp_status    out  2         pp_pkg::status_t: OK=0, BADOP=1, TIMEOUT=2
// - core_cmd      out  4         opcode to core; NOOP whenever not issuing
// - core_in1      out  NUM_SIZE  operand 1 to core
// - core_in2      out  NUM_SIZE  operand 2 to core
// - core_valid    in   1         core result valid
// - core_out      in   NUM_SIZE  core result
// - busy          out  1         state != IDLE
// BEHAVIOUR
// - Reset (async, reset_n=0): state=IDLE; req_ready=1; rsp_valid=0, rsp_data=0, rsp_status=OK; core_cmd=NOOP,
//   core_in1/in2=0; timeout counter=0. Reset mid-command drops it; no response is ever produced for it.
// - All outputs registered. FSM: IDLE -> ISSUE -> WAIT -> RESP -> IDLE.
// - IDLE: req_ready=1. On req_valid&&req_ready, latch op/a/b; req_ready drops the next cycle.
//   - op==NOOP: go to RESP with data=0, status=OK; core is not driven.
//   - op>MAX_OP: go to RESP with data=0, status=BADOP; core is not driven.
//   - otherwise go to ISSUE.
// - ISSUE: exactly one cycle with core_cmd=op, core_in1=a, core_in2=b; then core_cmd returns to NOOP.
//   core_in1/in2 hold their values until the next issue.
// - WAIT: counter increments every cycle. If core_valid=1, capture core_out, status=OK, go to RESP.
//   If the counter reaches TIMEOUT without core_valid, set data=0, status=TIMEOUT, and go to RESP.
//   If core_valid and timeout occur in the same cycle, core_valid wins.
// - core_valid outside WAIT is ignored; a late result after a timeout is discarded.
// - RESP: rsp_valid=1; data and status are held stable until rsp_ready. On rsp_valid&&rsp_ready,
//   drop rsp_valid next cycle and return to IDLE. req_ready returns to 1 one cycle later (no bypass).
// - Latency (core valid one cycle after issue): accept@0, ISSUE@1, WAIT@2 sees valid, rsp_valid@3.
// CONFIGURATION
// - PP_ISSUER_STATS_EN defined: adds outputs stat_issued[31:0] and stat_timeouts[31:0].
//   - stat_issued increments on each ISSUE cycle; stat_timeouts increments on each TIMEOUT response.
//   - Both saturate at all-ones and reset to 0.
// - PP_ISSUER_STATS_EN undefined: these ports and counters do not exist; all other behaviour is identical.
// STRUCTURE
// - pp_pkg holds: NUM_SIZE; op_t enum (NOOP=4'b0000, ...); status_t enum; state_t enum. Shared with the pp core.
// - One sub-module, pp_issue_timer: loadable down-counter with expired flag, instantiated for WAIT.
// TESTING
// - Normal op: req op=1, a=5, b=3; core model returns 8 one cycle after issue -> core_cmd=1 for exactly
//   1 cycle; rsp_valid @cycle 3; rsp_data=8, status=OK.
// - Bad opcode: op=4'hF -> core_cmd stays NOOP throughout; rsp status=BADOP, data=0.
// - Timeout: TIMEOUT=4, core never valid -> rsp after 4 WAIT cycles with status=TIMEOUT; then a late
//   core_valid is ignored and the next request works.
// - Backpressure: hold rsp_ready=0 for 10 cycles -> rsp_data/status stable, req_ready=0, no new issue.
// - Reset mid-WAIT: assert reset_n=0 during WAIT -> all outputs reach reset values immediately;
//   no response for the dropped command.
// - Stats (PP_ISSUER_STATS_EN): 3 good commands + 1 timeout -> stat_issued=4, stat_timeouts=1.

Source files
------------

// File: rtl/pp_pkg.sv
// Shared types for the pp datapath core and its command issuer.
package pp_pkg;
  localparam int NUM_SIZE = 32;

  typedef enum logic [3:0] {
    NOOP = 4'b0000,
    ADD  = 4'b0001
  } op_t;

  typedef enum logic [1:0] {
    ST_OK      = 2'd0,
    ST_BADOP   = 2'd1,
    ST_TIMEOUT = 2'd2
  } status_t;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_RESP
  } state_t;

  typedef struct packed {
    logic [3:0]          op;
    logic [NUM_SIZE-1:0] a;
    logic [NUM_SIZE-1:0] b;
  } pp_req_t;

  typedef struct packed {
    logic [NUM_SIZE-1:0] data;
    status_t             status;
  } pp_rsp_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == '1) ? v : v + 32'd1;
  endfunction
endpackage

// File: rtl/pp_cmd_issuer_if.sv
// Host-side request/response handshake bundle for pp_cmd_issuer.
interface pp_cmd_issuer_if;
  import pp_pkg::*;

  logic                req_valid;
  logic                req_ready;
  logic [3:0]          req_op;
  logic [NUM_SIZE-1:0] req_a;
  logic [NUM_SIZE-1:0] req_b;
  logic                rsp_valid;
  logic                rsp_ready;
  logic [NUM_SIZE-1:0] rsp_data;
  logic [1:0]          rsp_status;

  modport master (
    output req_valid, req_op, req_a, req_b, rsp_ready,
    input  req_ready, rsp_valid, rsp_data, rsp_status
  );

  modport slave (
    input  req_valid, req_op, req_a, req_b, rsp_ready,
    output req_ready, rsp_valid, rsp_data, rsp_status
  );
endinterface

// File: rtl/pp_issue_timer.sv
// Loadable down-counter; expired flags the last permitted cycle of a wait window.
module pp_issue_timer #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset_n,
  input  logic         load,
  input  logic         en,
  input  logic [W-1:0] load_val,
  output logic         expired
);
  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)               cnt <= '0;
    else if (load)              cnt <= load_val;
    else if (en && cnt != '0)   cnt <= cnt - W'(1);
  end

  assign expired = (cnt == W'(1));
endmodule

// File: rtl/pp_cmd_issuer.sv
// Single-outstanding command initiator between the host stream adapter and the pp core.
// Optional PP_ISSUER_STATS_EN adds saturating issue/timeout counters.
module pp_cmd_issuer import pp_pkg::*; #(
  parameter logic [3:0] MAX_OP  = 4'd1,
  parameter int         TIMEOUT = 255
) (
  input  logic                clk,
  input  logic                reset_n,
  pp_cmd_issuer_if.slave      host,
  output logic [3:0]          core_cmd,
  output logic [NUM_SIZE-1:0] core_in1,
  output logic [NUM_SIZE-1:0] core_in2,
  input  logic                core_valid,
  input  logic [NUM_SIZE-1:0] core_out,
  output logic                busy
`ifdef PP_ISSUER_STATS_EN
  ,
  output logic [31:0]         stat_issued,
  output logic [31:0]         stat_timeouts
`endif
);
  localparam int TW = $clog2(TIMEOUT + 1);

  state_t              state_q, state_d;
  logic                req_ready_q, req_ready_d;
  logic                rsp_valid_q, rsp_valid_d;
  pp_rsp_t             rsp_q, rsp_d;
  logic [3:0]          cmd_d;
  logic [NUM_SIZE-1:0] in1_d, in2_d;
  logic                tmr_load, tmr_en, tmr_expired;
  pp_req_t             req;

  assign req = '{op: host.req_op, a: host.req_a, b: host.req_b};

  pp_issue_timer #(.W(TW)) u_timer (
    .clk      (clk),
    .reset_n  (reset_n),
    .load     (tmr_load),
    .en       (tmr_en),
    .load_val (TW'(TIMEOUT)),
    .expired  (tmr_expired)
  );

  always_comb begin
    state_d     = state_q;
    req_ready_d = req_ready_q;
    rsp_valid_d = rsp_valid_q;
    rsp_d       = rsp_q;
    cmd_d       = NOOP;
    in1_d       = core_in1;
    in2_d       = core_in2;
    tmr_load    = 1'b0;
    tmr_en      = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (host.req_valid && req_ready_q) begin
          req_ready_d = 1'b0;
          if (req.op == NOOP) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_d       = '{data: '0, status: ST_OK};
          end else if (req.op > MAX_OP) begin
            state_d     = S_RESP;
            rsp_valid_d = 1'b1;
            rsp_d       = '{data: '0, status: ST_BADOP};
          end else begin
            state_d  = S_ISSUE;
            cmd_d    = req.op;
            in1_d    = req.a;
            in2_d    = req.b;
            tmr_load = 1'b1;
          end
        end
      end
      S_ISSUE: state_d = S_WAIT;
      S_WAIT: begin
        tmr_en = 1'b1;
        // A result arriving on the final allowed cycle still counts as a success.
        if (core_valid) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_d       = '{data: core_out, status: ST_OK};
        end else if (tmr_expired) begin
          state_d     = S_RESP;
          rsp_valid_d = 1'b1;
          rsp_d       = '{data: '0, status: ST_TIMEOUT};
        end
      end
      S_RESP: begin
        if (host.rsp_ready) begin
          state_d     = S_IDLE;
          rsp_valid_d = 1'b0;
          req_ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= S_IDLE;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_q       <= '{data: '0, status: ST_OK};
      core_cmd    <= NOOP;
      core_in1    <= '0;
      core_in2    <= '0;
      busy        <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_q       <= rsp_d;
      core_cmd    <= cmd_d;
      core_in1    <= in1_d;
      core_in2    <= in2_d;
      busy        <= (state_d != S_IDLE);
    end
  end

  assign host.req_ready  = req_ready_q;
  assign host.rsp_valid  = rsp_valid_q;
  assign host.rsp_data   = rsp_q.data;
  assign host.rsp_status = rsp_q.status;

`ifdef PP_ISSUER_STATS_EN
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      stat_issued   <= '0;
      stat_timeouts <= '0;
    end else begin
      if (state_q == S_ISSUE) stat_issued <= sat_inc(stat_issued);
      if (state_q == S_WAIT && state_d == S_RESP && rsp_d.status == ST_TIMEOUT)
        stat_timeouts <= sat_inc(stat_timeouts);
    end
  end
`endif
endmodule

// File: tb/tb_pp_cmd_issuer.sv
// Self-checking bench for pp_cmd_issuer: directed table, reset/stats sequences, random traffic.
module tb_pp_cmd_issuer;
  import pp_pkg::*;

  localparam int T = 4;

  logic clk = 1'b0;
  logic reset_n = 1'b0;
  always #5 clk = ~clk;

  pp_cmd_issuer_if ifc();
  logic [3:0]  core_cmd;
  logic [31:0] core_in1, core_in2, core_out;
  logic        core_valid;
  logic        busy;
`ifdef PP_ISSUER_STATS_EN
  logic [31:0] stat_issued, stat_timeouts;
`endif

  pp_cmd_issuer #(.MAX_OP(4'd1), .TIMEOUT(T)) dut (
    .clk        (clk),
    .reset_n    (reset_n),
    .host       (ifc),
    .core_cmd   (core_cmd),
    .core_in1   (core_in1),
    .core_in2   (core_in2),
    .core_valid (core_valid),
    .core_out   (core_out),
    .busy       (busy)
`ifdef PP_ISSUER_STATS_EN
    ,
    .stat_issued   (stat_issued),
    .stat_timeouts (stat_timeouts)
`endif
  );

  int errors = 0;
  int checks = 0;
  int exp_issued = 0;
  int exp_timeouts = 0;
  int core_lat = 1;    // cycles after the issue cycle that the core answers; 0 = never

  // Core stand-in: adds its operands and answers core_lat cycles after seeing a command.
  initial begin : core_model
    int pend;
    logic [31:0] res;
    pend = 0;
    res = '0;
    core_valid = 1'b0;
    core_out = '0;
    forever begin
      @(negedge clk);
      core_valid = 1'b0;
      if (pend > 0) begin
        pend--;
        if (pend == 0) begin
          core_valid = 1'b1;
          core_out = res;
        end
      end
      if (core_cmd != 4'd0) begin
        pend = core_lat;
        res = core_in1 + core_in2;
      end
    end
  end

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  // Transaction-level expectation from the opcode rules and the core's answer delay.
  task automatic model(input logic [3:0] op, input logic [31:0] a, input logic [31:0] b,
                       input int lat, output logic [31:0] d, output logic [1:0] st,
                       output int cyc, output int iss);
    if (op == 4'd0) begin
      d = 0; st = 2'd0; cyc = 1; iss = 0;
    end else if (op > 4'd1) begin
      d = 0; st = 2'd1; cyc = 1; iss = 0;
    end else if (lat >= 1 && lat <= T) begin
      d = a + b; st = 2'd0; cyc = lat + 2; iss = 1;
    end else begin
      d = 0; st = 2'd2; cyc = T + 2; iss = 1;
    end
  endtask

  task automatic run_txn(input string nm, input logic [3:0] op, input logic [31:0] a,
                         input logic [31:0] b, input int lat, input int rdy,
                         input logic [31:0] ed, input logic [1:0] es,
                         input int ecyc, input int eiss);
    int w, cyc, ncmd;
    logic [31:0] d0;
    logic [1:0]  s0;
    core_lat = lat;
    w = 0;
    while (!ifc.req_ready && w < 20) begin
      @(negedge clk);
      w++;
    end
    if (!ifc.req_ready) begin
      chk($sformatf("%s.req_ready_timeout", nm), 64'd0, 64'd1);
      return;
    end
    ifc.req_valid = 1'b1;
    ifc.req_op = op;
    ifc.req_a = a;
    ifc.req_b = b;
    @(negedge clk);
    ifc.req_valid = 1'b0;
    chk($sformatf("%s.req_ready_drop", nm), ifc.req_ready, 0);
    cyc = 1;
    ncmd = 0;
    while (!ifc.rsp_valid && cyc < 60) begin
      if (core_cmd != 4'd0) begin
        ncmd++;
        chk($sformatf("%s.core_cmd", nm), core_cmd, op);
        chk($sformatf("%s.core_in1", nm), core_in1, a);
        chk($sformatf("%s.core_in2", nm), core_in2, b);
      end
      @(negedge clk);
      cyc++;
    end
    chk($sformatf("%s.latency", nm), cyc, ecyc);
    chk($sformatf("%s.issue_cycles", nm), ncmd, eiss);
    if (!ifc.rsp_valid) return;
    chk($sformatf("%s.rsp_data", nm), ifc.rsp_data, ed);
    chk($sformatf("%s.rsp_status", nm), ifc.rsp_status, es);
    chk($sformatf("%s.busy_resp", nm), busy, 1);
    d0 = ifc.rsp_data;
    s0 = ifc.rsp_status;
    for (int i = 0; i < rdy; i++) begin
      ifc.req_valid = 1'b1;
      ifc.req_op = 4'd1;
      @(negedge clk);
      chk($sformatf("%s.hold_valid", nm), ifc.rsp_valid, 1);
      chk($sformatf("%s.hold_data", nm), ifc.rsp_data, d0);
      chk($sformatf("%s.hold_status", nm), ifc.rsp_status, s0);
      chk($sformatf("%s.hold_req_ready", nm), ifc.req_ready, 0);
      chk($sformatf("%s.hold_no_issue", nm), core_cmd, 0);
    end
    ifc.req_valid = 1'b0;
    ifc.rsp_ready = 1'b1;
    @(negedge clk);
    ifc.rsp_ready = 1'b0;
    chk($sformatf("%s.rsp_drop", nm), ifc.rsp_valid, 0);
    chk($sformatf("%s.req_ready_back", nm), ifc.req_ready, 1);
    chk($sformatf("%s.busy_idle", nm), busy, 0);
    exp_issued += eiss;
    if (es == 2'd2) exp_timeouts++;
  endtask

  task automatic txn(input string nm, input logic [3:0] op, input logic [31:0] a,
                     input logic [31:0] b, input int lat, input int rdy);
    logic [31:0] d;
    logic [1:0]  st;
    int cyc, iss;
    model(op, a, b, lat, d, st, cyc, iss);
    run_txn(nm, op, a, b, lat, rdy, d, st, cyc, iss);
  endtask

  task automatic chk_reset_vals(input string nm);
    chk({nm, ".req_ready"}, ifc.req_ready, 1);
    chk({nm, ".rsp_valid"}, ifc.rsp_valid, 0);
    chk({nm, ".rsp_data"}, ifc.rsp_data, 0);
    chk({nm, ".rsp_status"}, ifc.rsp_status, 0);
    chk({nm, ".core_cmd"}, core_cmd, 0);
    chk({nm, ".core_in1"}, core_in1, 0);
    chk({nm, ".core_in2"}, core_in2, 0);
    chk({nm, ".busy"}, busy, 0);
  endtask

  typedef struct {
    logic [3:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    int          lat;
    int          rdy;
    logic [31:0] ed;
    logic [1:0]  es;
  } vec_t;

  vec_t tbl[9];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] d;
    logic [1:0]  st;
    int cyc, iss;
    tbl[0] = '{4'd1, 32'd5, 32'd3, 1, 0, 32'd8, 2'd0};
    tbl[1] = '{4'hF, 32'd9, 32'd9, 1, 0, 32'd0, 2'd1};
    tbl[2] = '{4'd0, 32'd7, 32'd7, 1, 0, 32'd0, 2'd0};
    tbl[3] = '{4'd1, 32'hFFFF_FFF9, 32'd2, T, 0, 32'hFFFF_FFFB, 2'd0};
    tbl[4] = '{4'd1, 32'd1, 32'd1, 0, 0, 32'd0, 2'd2};
    tbl[5] = '{4'd1, 32'd2, 32'd2, T + 2, 0, 32'd0, 2'd2};
    tbl[6] = '{4'd1, 32'd100, 32'd23, 2, 0, 32'd123, 2'd0};
    tbl[7] = '{4'd2, 32'd1, 32'd1, 1, 0, 32'd0, 2'd1};
    tbl[8] = '{4'd1, 32'h7FFF_FFFF, 32'd1, 3, 10, 32'h8000_0000, 2'd0};

    ifc.req_valid = 1'b0;
    ifc.req_op = '0;
    ifc.req_a = '0;
    ifc.req_b = '0;
    ifc.rsp_ready = 1'b0;

    @(negedge clk);
    chk_reset_vals("reset");
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 9; i++) begin
      model(tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].lat, d, st, cyc, iss);
      run_txn($sformatf("tbl%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].lat,
              tbl[i].rdy, tbl[i].ed, tbl[i].es, cyc, iss);
    end

    // Reset while waiting on a core that never answers.
    core_lat = 0;
    ifc.req_valid = 1'b1;
    ifc.req_op = 4'd1;
    ifc.req_a = 32'h1234;
    ifc.req_b = 32'h5678;
    @(negedge clk);
    ifc.req_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    #2 reset_n = 1'b0;
    #1 chk_reset_vals("midwait_reset");
    @(negedge clk);
    reset_n = 1'b1;
    exp_issued = 0;
    exp_timeouts = 0;
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      chk("dropped_no_rsp", ifc.rsp_valid, 0);
    end
`ifdef PP_ISSUER_STATS_EN
    chk("stat_issued_reset", stat_issued, 0);
    chk("stat_timeouts_reset", stat_timeouts, 0);
`endif

    txn("stat_g0", 4'd1, 32'd10, 32'd20, 1, 0);
    txn("stat_g1", 4'd1, 32'd30, 32'd40, 2, 0);
    txn("stat_g2", 4'd1, 32'd50, 32'd60, 3, 1);
    txn("stat_to", 4'd1, 32'd70, 32'd80, 0, 0);
`ifdef PP_ISSUER_STATS_EN
    chk("stat_issued_4", stat_issued, 4);
    chk("stat_timeouts_1", stat_timeouts, 1);
`endif

    for (int i = 0; i < 40; i++) begin
      int r;
      logic [3:0] op;
      r = $urandom_range(0, 9);
      if (r < 6)      op = 4'd1;
      else if (r < 8) op = 4'd0;
      else            op = 4'($urandom_range(2, 15));
      txn($sformatf("rnd%0d", i), op, $urandom, $urandom,
          $urandom_range(0, T + 2), $urandom_range(0, 3));
    end
`ifdef PP_ISSUER_STATS_EN
    chk("stat_issued_final", stat_issued, exp_issued);
    chk("stat_timeouts_final", stat_timeouts, exp_timeouts);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
